// File: rtl/nvdla_apb2csb_pkg.sv
// Shared types and helpers for the APB-to-CSB bridge.
package nvdla_apb2csb_pkg;

   localparam int STATE_W = 3;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_0BAD;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      RD_WAIT = 3'd2,
      WR_WAIT = 3'd3,
      DONE    = 3'd4
   } state_e;

   // Address is decodable when every bit above the CSB word range is clear.
   function automatic logic addr_in_range(input logic [31:0] paddr, input int addr_w);
      logic [31:0] hi_s;
      hi_s = paddr >> (addr_w + 2);
      return (hi_s == 32'd0);
   endfunction

endpackage

// File: rtl/nvdla_apb2csb_tmo_cnt.sv
// Saturating wait-cycle counter; tc flags the all-ones terminal count.
module nvdla_apb2csb_tmo_cnt #(
   parameter int TMO_W = 12
) (
   input  logic pclk,
   input  logic prstn,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);

   logic [TMO_W-1:0] cnt_r;

   assign tc = &cnt_r;

   // Count wait cycles, holding at the terminal value.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en && !tc) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

endmodule

// File: rtl/nvdla_apb2csb_bridge.sv
// APB3 slave that turns each access into a single CSB request and returns
// the CSB response (or a timeout / decode error) with a one-cycle pready.
module nvdla_apb2csb_bridge
   import nvdla_apb2csb_pkg::*;
#(
   parameter int          ADDR_W     = 16,
   parameter int          NPOSTED_WR = 0,
   parameter int          ADDR_CHECK = 1,
   parameter int          TMO_W      = 12,
   parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
   input  logic              pclk,
   input  logic              prstn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [31:0]       paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              csb2nvdla_valid,
   input  logic              csb2nvdla_ready,
   output logic [ADDR_W-1:0] csb2nvdla_addr,
   output logic [31:0]       csb2nvdla_wdat,
   output logic              csb2nvdla_write,
   output logic              csb2nvdla_nposted,
   input  logic              nvdla2csb_valid,
   input  logic [31:0]       nvdla2csb_data,
   input  logic              nvdla2csb_wr_complete
);

   state_e            state_r,   nxt_state_s;
   logic [ADDR_W-1:0] addr_r,    nxt_addr_s;
   logic [31:0]       wdat_r,    nxt_wdat_s;
   logic              write_r,   nxt_write_s;
   logic              nposted_r, nxt_nposted_s;
   logic              err_r,     nxt_err_s;
   logic [31:0]       rdata_r,   nxt_rdata_s;
   logic              valid_r,   nxt_valid_s;
   logic              pready_r,  nxt_pready_s;
   logic              pslverr_r, nxt_pslverr_s;
   logic [31:0]       prdata_r,  nxt_prdata_s;
   logic              tmo_clr_s, tmo_en_s, tmo_tc_s;

   assign tmo_clr_s = (state_r == IDLE) || (state_r == DONE);
   assign tmo_en_s  = !tmo_clr_s;

   nvdla_apb2csb_tmo_cnt #(.TMO_W(TMO_W)) u_tmo_cnt (
      .pclk  (pclk),
      .prstn (prstn),
      .clr   (tmo_clr_s),
      .en    (tmo_en_s),
      .tc    (tmo_tc_s)
   );

   // Next-state and next-output decode; a response beats a same-cycle timeout.
   always_comb begin
      nxt_state_s   = state_r;
      nxt_addr_s    = addr_r;
      nxt_wdat_s    = wdat_r;
      nxt_write_s   = write_r;
      nxt_nposted_s = nposted_r;
      nxt_err_s     = err_r;
      nxt_rdata_s   = rdata_r;
      case (state_r)
         IDLE: begin
            if (psel && penable && !pready_r) begin
               nxt_addr_s    = paddr[ADDR_W+1:2];
               nxt_wdat_s    = pwdata;
               nxt_write_s   = pwrite;
               nxt_nposted_s = pwrite && (NPOSTED_WR != 0);
               nxt_rdata_s   = 32'h0000_0000;
               if ((ADDR_CHECK != 0) && !addr_in_range(paddr, ADDR_W)) begin
                  nxt_err_s   = 1'b1;
                  nxt_rdata_s = pwrite ? 32'h0000_0000 : ERR_DATA;
                  nxt_state_s = DONE;
               end else begin
                  nxt_err_s   = 1'b0;
                  nxt_state_s = REQ;
               end
            end else begin
               nxt_state_s = IDLE;
            end
         end
         REQ: begin
            if (csb2nvdla_ready) begin
               if (!write_r) begin
                  nxt_state_s = RD_WAIT;
               end else if (nposted_r) begin
                  nxt_state_s = WR_WAIT;
               end else begin
                  nxt_state_s = DONE;
               end
            end else if (tmo_tc_s) begin
               nxt_err_s   = 1'b1;
               nxt_rdata_s = write_r ? 32'h0000_0000 : ERR_DATA;
               nxt_state_s = DONE;
            end else begin
               nxt_state_s = REQ;
            end
         end
         RD_WAIT: begin
            if (nvdla2csb_valid) begin
               nxt_rdata_s = nvdla2csb_data;
               nxt_state_s = DONE;
            end else if (tmo_tc_s) begin
               nxt_err_s   = 1'b1;
               nxt_rdata_s = ERR_DATA;
               nxt_state_s = DONE;
            end else begin
               nxt_state_s = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (nvdla2csb_wr_complete) begin
               nxt_state_s = DONE;
            end else if (tmo_tc_s) begin
               nxt_err_s   = 1'b1;
               nxt_state_s = DONE;
            end else begin
               nxt_state_s = WR_WAIT;
            end
         end
         DONE: begin
            nxt_state_s = IDLE;
         end
         default: begin
            nxt_state_s = IDLE;
         end
      endcase
      nxt_valid_s   = (nxt_state_s == REQ);
      nxt_pready_s  = (nxt_state_s == DONE);
      nxt_pslverr_s = (nxt_state_s == DONE) && nxt_err_s;
      nxt_prdata_s  = (nxt_state_s == DONE) ? nxt_rdata_s : 32'h0000_0000;
   end

   // State, request and response registers.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state_r   <= IDLE;
         addr_r    <= '0;
         wdat_r    <= 32'h0000_0000;
         write_r   <= 1'b0;
         nposted_r <= 1'b0;
         err_r     <= 1'b0;
         rdata_r   <= 32'h0000_0000;
         valid_r   <= 1'b0;
         pready_r  <= 1'b0;
         pslverr_r <= 1'b0;
         prdata_r  <= 32'h0000_0000;
      end else begin
         state_r   <= nxt_state_s;
         addr_r    <= nxt_addr_s;
         wdat_r    <= nxt_wdat_s;
         write_r   <= nxt_write_s;
         nposted_r <= nxt_nposted_s;
         err_r     <= nxt_err_s;
         rdata_r   <= nxt_rdata_s;
         valid_r   <= nxt_valid_s;
         pready_r  <= nxt_pready_s;
         pslverr_r <= nxt_pslverr_s;
         prdata_r  <= nxt_prdata_s;
      end
   end

   assign prdata            = prdata_r;
   assign pready            = pready_r;
   assign pslverr           = pslverr_r;
   assign csb2nvdla_valid   = valid_r;
   assign csb2nvdla_addr    = addr_r;
   assign csb2nvdla_wdat    = wdat_r;
   assign csb2nvdla_write   = write_r;
   assign csb2nvdla_nposted = nposted_r;

endmodule

// File: tb/tb_nvdla_apb2csb_bridge.sv
// Scoreboard bench: two bridge instances (posted and non-posted writes, short timeout)
// sharing APB/CSB stimulus; monitors pop expected APB responses and CSB requests.
module tb_nvdla_apb2csb_bridge;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] wdat;
      logic        write;
      logic        nposted;
   } csb_t;

   logic        pclk = 1'b0;
   logic        prstn;
   logic        psel_a, psel_b, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        csb_ready, nv_valid, nv_wr_complete;
   logic [31:0] nv_data;

   logic [31:0] prdata_a, prdata_b, wdat_a, wdat_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;
   logic        valid_a, valid_b, write_a, write_b, nposted_a, nposted_b;
   logic [15:0] addr_a, addr_b;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   t0;
   rsp_t rsp_q_a[$], rsp_q_b[$];
   csb_t csb_q_a[$], csb_q_b[$];

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   nvdla_apb2csb_bridge #(.ADDR_W(16), .NPOSTED_WR(0), .ADDR_CHECK(1), .TMO_W(4)) dut_a (
      .pclk(pclk), .prstn(prstn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
      .csb2nvdla_valid(valid_a), .csb2nvdla_ready(csb_ready), .csb2nvdla_addr(addr_a),
      .csb2nvdla_wdat(wdat_a), .csb2nvdla_write(write_a), .csb2nvdla_nposted(nposted_a),
      .nvdla2csb_valid(nv_valid), .nvdla2csb_data(nv_data), .nvdla2csb_wr_complete(nv_wr_complete)
   );

   nvdla_apb2csb_bridge #(.ADDR_W(16), .NPOSTED_WR(1), .ADDR_CHECK(1), .TMO_W(4)) dut_b (
      .pclk(pclk), .prstn(prstn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
      .csb2nvdla_valid(valid_b), .csb2nvdla_ready(csb_ready), .csb2nvdla_addr(addr_b),
      .csb2nvdla_wdat(wdat_b), .csb2nvdla_write(write_b), .csb2nvdla_nposted(nposted_b),
      .nvdla2csb_valid(nv_valid), .nvdla2csb_data(nv_data), .nvdla2csb_wr_complete(nv_wr_complete)
   );

   // Monitor: every pready or CSB handshake must match the head of its queue.
   always @(negedge pclk) begin : monitor
      rsp_t r;
      csb_t c;
      if (prstn) begin
         if (pready_a) begin
            n_cmp++;
            if (rsp_q_a.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_a: unexpected pready at cycle %0d prdata=%h pslverr=%b", cyc, prdata_a, pslverr_a);
            end else begin
               r = rsp_q_a.pop_front();
               if (cyc != r.cyc || prdata_a !== r.rdata || pslverr_a !== r.err) begin
                  n_fail++;
                  $display("FAIL rsp_a: got cyc=%0d prdata=%h pslverr=%b, expected cyc=%0d prdata=%h pslverr=%b",
                           cyc, prdata_a, pslverr_a, r.cyc, r.rdata, r.err);
               end
            end
         end
         if (pready_b) begin
            n_cmp++;
            if (rsp_q_b.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_b: unexpected pready at cycle %0d prdata=%h pslverr=%b", cyc, prdata_b, pslverr_b);
            end else begin
               r = rsp_q_b.pop_front();
               if (cyc != r.cyc || prdata_b !== r.rdata || pslverr_b !== r.err) begin
                  n_fail++;
                  $display("FAIL rsp_b: got cyc=%0d prdata=%h pslverr=%b, expected cyc=%0d prdata=%h pslverr=%b",
                           cyc, prdata_b, pslverr_b, r.cyc, r.rdata, r.err);
               end
            end
         end
         if (valid_a && csb_ready) begin
            n_cmp++;
            if (csb_q_a.size() == 0) begin
               n_fail++;
               $display("FAIL csb_a: unexpected request at cycle %0d addr=%h", cyc, addr_a);
            end else begin
               c = csb_q_a.pop_front();
               if (addr_a !== c.addr || wdat_a !== c.wdat || write_a !== c.write || nposted_a !== c.nposted) begin
                  n_fail++;
                  $display("FAIL csb_a: got addr=%h wdat=%h write=%b nposted=%b, expected addr=%h wdat=%h write=%b nposted=%b",
                           addr_a, wdat_a, write_a, nposted_a, c.addr, c.wdat, c.write, c.nposted);
               end
            end
         end
         if (valid_b && csb_ready) begin
            n_cmp++;
            if (csb_q_b.size() == 0) begin
               n_fail++;
               $display("FAIL csb_b: unexpected request at cycle %0d addr=%h", cyc, addr_b);
            end else begin
               c = csb_q_b.pop_front();
               if (addr_b !== c.addr || wdat_b !== c.wdat || write_b !== c.write || nposted_b !== c.nposted) begin
                  n_fail++;
                  $display("FAIL csb_b: got addr=%h wdat=%h write=%b nposted=%b, expected addr=%h wdat=%h write=%b nposted=%b",
                           addr_b, wdat_b, write_b, nposted_b, c.addr, c.wdat, c.write, c.nposted);
               end
            end
         end
      end
   end

   task automatic chk_zero(input string nm, input logic [84:0] act);
      n_cmp++;
      if (act !== 85'd0) begin
         n_fail++;
         $display("FAIL %s: outputs=%h, expected all zero", nm, act);
      end
   endtask

   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge pclk);
         #1;
      end
   endtask

   task automatic apb_start(input logic use_b, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, output int t);
      @(posedge pclk);
      #1;
      psel_a  = !use_b;
      psel_b  = use_b;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      t = cyc;
   endtask

   task automatic apb_finish(input logic use_b, input string nm);
      logic got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge pclk);
         got = use_b ? pready_b : pready_a;
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no pready within 40 cycles, expected a response", nm);
      end
      @(posedge pclk);
      #1;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      prstn = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'd0; pwdata = 32'd0; csb_ready = 1'b0; nv_valid = 1'b0;
      nv_wr_complete = 1'b0; nv_data = 32'd0;
      repeat (3) @(posedge pclk);
      #1;
      chk_zero("reset_a", {prdata_a, pready_a, pslverr_a, valid_a, addr_a, wdat_a, write_a, nposted_a});
      chk_zero("reset_b", {prdata_b, pready_b, pslverr_b, valid_b, addr_b, wdat_b, write_b, nposted_b});
      prstn = 1'b1;

      // 1: posted write, ready high, pready two cycles after the access phase
      csb_ready = 1'b1;
      apb_start(1'b0, 1'b1, 32'h0000_1004, 32'hA5A5_0001, t0);
      csb_q_a.push_back('{16'h0401, 32'hA5A5_0001, 1'b1, 1'b0});
      rsp_q_a.push_back('{t0 + 2, 32'h0, 1'b0});
      apb_finish(1'b0, "posted_wr");
      csb_ready = 1'b0;

      // 2: read, ready at T3, data at T5, pready at T6
      apb_start(1'b0, 1'b0, 32'h0000_0008, 32'h0, t0);
      csb_q_a.push_back('{16'h0002, 32'h0, 1'b0, 1'b0});
      rsp_q_a.push_back('{t0 + 6, 32'h1234_5678, 1'b0});
      at_cycle(t0 + 3); csb_ready = 1'b1;
      at_cycle(t0 + 4); csb_ready = 1'b0;
      at_cycle(t0 + 5); nv_valid = 1'b1; nv_data = 32'h1234_5678;
      at_cycle(t0 + 6); nv_valid = 1'b0; nv_data = 32'h0;
      apb_finish(1'b0, "read");

      // 3: non-posted write, completion at T6, pready at T7
      csb_ready = 1'b1;
      apb_start(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, t0);
      csb_q_b.push_back('{16'h0004, 32'hCAFE_F00D, 1'b1, 1'b1});
      rsp_q_b.push_back('{t0 + 7, 32'h0, 1'b0});
      at_cycle(t0 + 2); csb_ready = 1'b0;
      at_cycle(t0 + 6); nv_wr_complete = 1'b1;
      at_cycle(t0 + 7); nv_wr_complete = 1'b0;
      apb_finish(1'b1, "nposted_wr");

      // 4: read timeout: REQ at T1, 15 RD_WAIT cycles, error at T17, then a late response
      csb_ready = 1'b1;
      apb_start(1'b0, 1'b0, 32'h0000_0020, 32'h0, t0);
      csb_q_a.push_back('{16'h0008, 32'h0, 1'b0, 1'b0});
      rsp_q_a.push_back('{t0 + 17, 32'hDEAD_0BAD, 1'b1});
      at_cycle(t0 + 2); csb_ready = 1'b0;
      apb_finish(1'b0, "timeout");
      nv_valid = 1'b1; nv_data = 32'h9999_9999;
      at_cycle(cyc + 1); nv_valid = 1'b0; nv_data = 32'h0;
      at_cycle(cyc + 4);

      // 5: out-of-range address: no CSB request, error at T1
      csb_ready = 1'b1;
      apb_start(1'b0, 1'b1, 32'h0004_0000, 32'h1111_2222, t0);
      rsp_q_a.push_back('{t0 + 1, 32'h0, 1'b1});
      apb_finish(1'b0, "addr_err");
      at_cycle(cyc + 3);

      // 6: reset while in RD_WAIT, stray response afterwards, then a normal read
      apb_start(1'b0, 1'b0, 32'h0000_000C, 32'h0, t0);
      csb_q_a.push_back('{16'h0003, 32'h0, 1'b0, 1'b0});
      at_cycle(t0 + 2); csb_ready = 1'b0;
      at_cycle(t0 + 4);
      prstn = 1'b0;
      #1;
      chk_zero("mid_reset_a", {prdata_a, pready_a, pslverr_a, valid_a, addr_a, wdat_a, write_a, nposted_a});
      psel_a = 1'b0; penable = 1'b0;
      at_cycle(t0 + 6);
      prstn = 1'b1; nv_valid = 1'b1; nv_data = 32'h5555_AAAA;
      at_cycle(cyc + 1); nv_valid = 1'b0; nv_data = 32'h0;
      at_cycle(cyc + 2);
      csb_ready = 1'b1;
      apb_start(1'b0, 1'b0, 32'h0000_000C, 32'h0, t0);
      csb_q_a.push_back('{16'h0003, 32'h0, 1'b0, 1'b0});
      rsp_q_a.push_back('{t0 + 3, 32'h0BAD_F00D, 1'b0});
      at_cycle(t0 + 2); csb_ready = 1'b0; nv_valid = 1'b1; nv_data = 32'h0BAD_F00D;
      at_cycle(t0 + 3); nv_valid = 1'b0; nv_data = 32'h0;
      apb_finish(1'b0, "post_reset_rd");

      at_cycle(cyc + 5);
      n_cmp++;
      if (rsp_q_a.size() + rsp_q_b.size() + csb_q_a.size() + csb_q_b.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d rsp and %0d/%0d csb entries left, expected 0",
                  rsp_q_a.size(), rsp_q_b.size(), csb_q_a.size(), csb_q_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
